// File: rtl/fetch_resp_buffer.sv
// fetch_resp_buffer: in-order fetch response buffer with PC-tagged slots and flush drop accounting
module fetch_resp_buffer #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_issue,
   input  logic [ADDR_WIDTH-1:0] req_pc,
   output logic                  req_ready,
   input  logic                  resp_valid,
   input  logic [WIDTH-1:0]      resp_data,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0]      out_inst,
   input  logic                  out_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] ONE = PW'(1);
   localparam logic [PW:0]   CAP = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_pc_mem [DEPTH];
   logic [WIDTH-1:0]      r_inst_mem [DEPTH];
   logic [PW-1:0]         r_alloc_ptr, r_fill_ptr, r_head_ptr, r_drop_cnt;
   logic [PW-1:0]         w_pending, w_held;
   logic                  w_pop, w_fill, w_drop;

   assign w_pending = r_alloc_ptr - r_fill_ptr;
   assign w_held    = r_alloc_ptr - r_head_ptr;
   // In-flight responses owed to flushed requests still occupy capacity until they arrive
   assign req_ready = ({1'b0, w_held} + {1'b0, r_drop_cnt}) < CAP;
   assign out_valid = (r_fill_ptr != r_head_ptr) && !flush;
   assign out_pc    = r_pc_mem[r_head_ptr[AW-1:0]];
   assign out_inst  = r_inst_mem[r_head_ptr[AW-1:0]];
   assign w_pop     = out_valid && out_ready;
   assign w_drop    = resp_valid && !flush && (r_drop_cnt != '0);
   assign w_fill    = resp_valid && !flush && (r_drop_cnt == '0);

   // Slot storage: PC written on issue, instruction written on an accepted response
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]   <= '0;
            r_inst_mem[i] <= '0;
         end
      end else begin
         if (req_issue) r_pc_mem[r_alloc_ptr[AW-1:0]] <= req_pc;
         if (w_fill) r_inst_mem[r_fill_ptr[AW-1:0]] <= resp_data;
      end
   end

   // Pointer and drop-count update; flush discards queued work and converts pending requests into drops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (req_issue) r_alloc_ptr <= r_alloc_ptr + ONE;
         if (flush) begin
            r_head_ptr <= r_alloc_ptr;
            r_fill_ptr <= r_alloc_ptr;
            r_drop_cnt <= r_drop_cnt + w_pending - {{AW{1'b0}}, resp_valid};
         end else begin
            if (w_fill) r_fill_ptr <= r_fill_ptr + ONE;
            if (w_drop) r_drop_cnt <= r_drop_cnt - ONE;
            if (w_pop) r_head_ptr <= r_head_ptr + ONE;
         end
      end
   end
endmodule

// File: doc/fetch_resp_buffer.md
# fetch_resp_buffer

In-order instruction-fetch response buffer on the return side of the fetch request path. Each accepted fetch request reserves a slot tagged with its PC. The in-order memory response fills that slot, and filled slots drain to decode through a valid/ready handshake. On a pipeline flush, every queued entry is discarded, and responses still in flight for pre-flush requests are counted and dropped on arrival.

## Interface
- WIDTH, 32: instruction word width.
- ADDR_WIDTH, 32: PC width.
- DEPTH, 4: slot count. Power of two, at least 2. Also the bound on requests in flight plus entries held.

Reset is rst, synchronous, active-high; the clock is clk.

- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_issue  in  1  memory accepted a fetch request this cycle. Must be 0 when req_ready=0.
- req_pc  in  ADDR_WIDTH  PC of the request accepted this cycle.
- req_ready  out  1  a new request may be issued.
- resp_valid  in  1  one response word is returned, in request order.
- resp_data  in  WIDTH  instruction word of the response.
- flush  in  1  pipeline redirect; discard all pre-flush work.
- out_valid  out  1  head slot is filled and presentable.
- out_pc  out  ADDR_WIDTH  PC of the head slot.
- out_inst  out  WIDTH  instruction of the head slot.
- out_ready  in  1  decode accepts the head this cycle.

## Operation
- Storage: pc_mem[DEPTH], inst_mem[DEPTH], both reset to 0.
- Pointers: alloc_ptr, fill_ptr and head_ptr, each log2(DEPTH)+1 bits; the low bits index storage and the pointers wrap naturally.
- drop_cnt: log2(DEPTH)+1 bits, reset 0.
- Derived counts:
  - pending = alloc_ptr - fill_ptr (issued, no response yet).
  - held = alloc_ptr - head_ptr (allocated, not yet drained).
- req_ready = (held + drop_cnt) < DEPTH, computed combinationally from registers only.
- Issue (req_issue=1): pc_mem[alloc_ptr] <= req_pc, then alloc_ptr++.
- Response (resp_valid=1, no flush):
  - If drop_cnt>0: drop_cnt--; the data is discarded and fill_ptr is unchanged.
  - Otherwise: inst_mem[fill_ptr] <= resp_data, then fill_ptr++.
- Output:
  - out_valid = (fill_ptr != head_ptr) && !flush.
  - out_pc = pc_mem[head_ptr], out_inst = inst_mem[head_ptr].
  - Pop (head_ptr++) when out_valid && out_ready.
- Flush (takes priority over pop and response):
  - head_ptr <= alloc_ptr, fill_ptr <= alloc_ptr.
  - drop_cnt <= drop_cnt + pending - resp_valid. A response in the flush cycle is always pre-flush and is discarded.
  - A req_issue in the flush cycle is post-flush: it is written at the old alloc_ptr and alloc_ptr advances, so it becomes the new head.
- Simultaneous issue, response and pop (no flush): all three apply independently in the same cycle.
- Protocol violations (resp_valid with pending+drop_cnt=0, or req_issue with req_ready=0) are undefined behaviour. The verification engineer flags them with assertions.

## Timing
- Reset:
  - All pointers 0, drop_cnt 0, all storage 0.
  - Outputs: req_ready=1, out_valid=0, out_pc=0, out_inst=0.
  - rst overrides flush and all inputs. Any in-flight work at reset is lost; the memory side is reset together with this block.
- Latency: resp_valid at cycle N gives out_valid=1 at N+1, provided the slot is the head. There is no same-cycle bypass.
- Throughput: one issue, one response and one pop per cycle, sustained.
- req_ready updates the cycle after the event that changes held or drop_cnt. A pop at cycle N frees capacity at N+1.
- Full: held+drop_cnt = DEPTH gives req_ready=0. The buffer never overruns, because memory responses are bounded by the reservations already made.
- Empty: fill_ptr = head_ptr gives out_valid=0, and out_pc/out_inst show stale slot contents.
- After a flush at cycle N:
  - out_valid=0 at N.
  - The first post-flush response is accepted only after drop_cnt reaches 0.

## Test plan
- Reset, then issue PCs 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles with responses 0xA0, 0xA1, 0xA2 two cycles after each issue and out_ready=1 -> three pops in order with matching pc/inst pairs; each out_valid appears one cycle after its response.
- Issue 4 requests with no responses -> req_ready=0 after the 4th. Deliver one response and pop it -> req_ready=1 the following cycle. A 5th issue lands in slot 0 via wrap-around.
- Issue 3 requests, deliver 1 response, hold out_ready=0, then flush -> out_valid=0, drop_cnt=2. The next 2 responses are discarded. A request issued in the flush cycle with PC 0x1c000100 and response 0xBB is then presented as the head.
- Flush in the same cycle as a response, with pending=2 and drop_cnt=0 -> drop_cnt=1 and the response is discarded.
- Hold out_ready=0 until 4 slots are filled, then release -> 4 back-to-back pops. Simultaneous issue+response+pop cycles keep held constant.
- Assert rst mid-operation with drop_cnt=2 and held=3 -> the next cycle shows all outputs at their reset values and req_ready=1.
